// File: rtl/conv_window_fetch.sv
// Sequential 3x3 valid-mode window fetcher reading a row-major feature map from the pixel RAM.
// Optional column reuse between horizontally adjacent windows: define CONV_WINDOW_REUSE_EN.
module conv_window_fetch #(
  parameter int picture_size     = 28,
  parameter int SIZE_1           = 16,
  parameter int SIZE_address_pix = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [SIZE_address_pix-1:0]   base_addr,
  output logic [SIZE_address_pix-1:0]   read_addressp,
  output logic                          re_p,
  input  logic [SIZE_1-1:0]             qp,
  output logic                          win_valid,
  input  logic                          win_ready,
  output logic [9*SIZE_1-1:0]           win_data,
  output logic [SIZE_address_pix-1:0]   win_row,
  output logic [SIZE_address_pix-1:0]   win_col,
  output logic                          busy,
  output logic                          done
);

  localparam int AW = SIZE_address_pix;
  localparam logic [AW-1:0] PS   = AW'(picture_size);
  localparam logic [AW-1:0] LAST = AW'(picture_size - 3);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, OUT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           base_q, row_q, col_q;
  logic [1:0]              tap_i_q, tap_j_q;
  logic [1:0]              j_first;
  logic [3:0]              cap_k_q;
  logic                    cap_en_q;
  logic [8:0][SIZE_1-1:0]  win_q;
  logic [AW-1:0]           tap_addr;
  logic                    last_tap, col_wrap, last_win, accept;

`ifdef CONV_WINDOW_REUSE_EN
  logic reuse_q;
  assign j_first = reuse_q ? 2'd2 : 2'd0;
`else
  assign j_first = 2'd0;
`endif

  assign tap_addr = base_q + (row_q + AW'(tap_i_q)) * PS + col_q + AW'(tap_j_q);
  assign last_tap = (tap_i_q == 2'd2) && (tap_j_q == 2'd2);
  assign col_wrap = (col_q == LAST);
  assign last_win = col_wrap && (row_q == LAST);
  assign accept   = (state_q == OUT) && win_ready;

  assign win_data = win_q;
  assign win_row  = row_q;
  assign win_col  = col_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d       = state_q;
    re_p          = 1'b0;
    read_addressp = '0;
    win_valid     = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = FETCH;
      end
      FETCH: begin
        re_p          = 1'b1;
        read_addressp = tap_addr;
        if (last_tap) state_d = DRAIN;
      end
      DRAIN: state_d = OUT;
      OUT: begin
        win_valid = 1'b1;
        if (win_ready) state_d = last_win ? DONE : FETCH;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the window registers are reset too, so win_data reads 0 straight out of reset.
      base_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      tap_i_q  <= '0;
      tap_j_q  <= '0;
      cap_k_q  <= '0;
      cap_en_q <= 1'b0;
      win_q    <= '0;
`ifdef CONV_WINDOW_REUSE_EN
      reuse_q  <= 1'b0;
`endif
    end else begin
      // RAM data trails the read by one cycle, so the tap index is delayed alongside it.
      cap_en_q <= (state_q == FETCH);
      cap_k_q  <= {2'b00, tap_i_q} * 4'd3 + {2'b00, tap_j_q};
      if (cap_en_q) win_q[cap_k_q] <= qp;

      if (state_q == IDLE && start) begin
        base_q  <= base_addr;
        row_q   <= '0;
        col_q   <= '0;
        tap_i_q <= '0;
        tap_j_q <= '0;
`ifdef CONV_WINDOW_REUSE_EN
        reuse_q <= 1'b0;
`endif
      end

      if (state_q == FETCH) begin
        if (tap_j_q == 2'd2) begin
          tap_i_q <= tap_i_q + 2'd1;
          tap_j_q <= j_first;
        end else begin
          tap_j_q <= tap_j_q + 2'd1;
        end
      end

      if (accept) begin
        tap_i_q <= '0;
        if (col_wrap) begin
          col_q <= '0;
          row_q <= row_q + AW'(1);
        end else begin
          col_q <= col_q + AW'(1);
        end
`ifdef CONV_WINDOW_REUSE_EN
        // Moving right along a row: slide columns 1-2 into 0-1 and refetch only column 2.
        reuse_q <= !col_wrap;
        tap_j_q <= col_wrap ? 2'd0 : 2'd2;
        if (!col_wrap) begin
          for (int i = 0; i < 3; i++) begin
            win_q[3*i]     <= win_q[3*i + 1];
            win_q[3*i + 1] <= win_q[3*i + 2];
          end
        end
`else
        tap_j_q <= 2'd0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_conv_window_fetch.sv
// Scoreboard bench for conv_window_fetch (picture_size=5) against a RAM model holding mem[a] = a ^ key.
module tb_conv_window_fetch;

  localparam int PS = 5;
  localparam int W  = 16;
  localparam int AW = 16;
  localparam int NWIN = (PS - 2) * (PS - 2);
`ifdef CONV_WINDOW_REUSE_EN
  localparam bit REUSE = 1'b1;
  localparam int EXP_READS = (PS - 2) * (9 + 3 * (PS - 3));
`else
  localparam bit REUSE = 1'b0;
  localparam int EXP_READS = NWIN * 9;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic [AW-1:0]     read_addressp;
  logic              re_p;
  logic [W-1:0]      qp = '0;
  logic              win_valid;
  logic              win_ready;
  logic [9*W-1:0]    win_data;
  logic [AW-1:0]     win_row, win_col;
  logic              busy, done;

  conv_window_fetch #(.picture_size(PS), .SIZE_1(W), .SIZE_address_pix(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .read_addressp(read_addressp), .re_p(re_p), .qp(qp),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_row(win_row), .win_col(win_col), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]       row;
    logic [AW-1:0]       col;
    logic [8:0][W-1:0]   taps;
    logic                last;
    logic [7:0]          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_err = 0;
  int          n_checks = 0;
  logic [W-1:0] ram_key = '0;
  int          ready_pct = 100;
  int          stall_cnt = 0;
  int          hs_count = 0;

  function automatic logic [W-1:0] ram_word(input logic [AW-1:0] a);
    return W'(a) ^ ram_key;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pixel RAM: registered read port.
  always @(posedge clk) if (re_p) qp <= ram_word(read_addressp);

  initial begin
    win_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_cnt > 0) begin
        win_ready = 1'b0;
        stall_cnt--;
      end else begin
        win_ready = ($urandom_range(0, 99) < ready_pct);
      end
    end
  end

  // Reference: every valid window in raster order, taps straight from the address formula.
  task automatic push_pass(input logic [AW-1:0] base);
    exp_t e;
    for (int r = 0; r < PS - 2; r++)
      for (int c = 0; c < PS - 2; c++) begin
        e.row  = AW'(r);
        e.col  = AW'(c);
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.taps[3*i + j] = ram_word(AW'(int'(base) + (r + i) * PS + c + j));
        e.last = (r == PS - 3) && (c == PS - 3);
        e.lat  = (REUSE && c > 0) ? 8'd5 : 8'd11;
        exp_q.push_back(e);
      end
  endtask

  // Monitor
  int            cyc = 0, ref_cyc = 0, reads = 0;
  bit            expect_done = 0, prev_valid = 0, prev_hs = 0, prev_stall = 0;
  logic [9*W-1:0] held_data;
  logic [AW-1:0] held_row, held_col;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      expect_done = 0; prev_valid = 0; prev_hs = 0; prev_stall = 0; reads = 0;
    end else begin
      if (start && !busy) begin
        ref_cyc  = cyc;
        reads    = 0;
        hs_count = 0;
      end
      if (re_p) reads++;
      if (expect_done) begin
        check("done_pulse", done, 1);
        check("read_count", reads, EXP_READS);
        expect_done = 0;
      end else if (done) begin
        check("done_spurious", done, 0);
      end
      if (prev_hs) check("valid_after_handshake", win_valid, 0);
      if (prev_stall) begin
        check("stall_valid", win_valid, 1);
        check("stall_data_stable", win_data == held_data, 1);
        check("stall_row_stable", win_row, held_row);
        check("stall_col_stable", win_col, held_col);
      end
      if (win_valid) begin
        check("no_read_in_out", re_p, 0);
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL unexpected_window: got row %0d col %0d expected none", win_row, win_col);
          end else begin
            check("window_latency", cyc - ref_cyc, exp_q[0].lat);
          end
        end
        if (win_ready && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("win_row", win_row, e.row);
          check("win_col", win_col, e.col);
          for (int k = 0; k < 9; k++)
            check($sformatf("tap%0d_r%0d_c%0d", k, e.row, e.col), win_data[k*W +: W], e.taps[k]);
          if (e.last) expect_done = 1;
          ref_cyc = cyc;
          hs_count++;
        end
      end
      prev_hs    = win_valid && win_ready;
      prev_stall = win_valid && !win_ready;
      prev_valid = win_valid;
      held_data  = win_data;
      held_row   = win_row;
      held_col   = win_col;
    end
  end

  task automatic pulse_start(input logic [AW-1:0] base, input bit expect_pass);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = base;
    if (expect_pass) push_pass(base);
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = $urandom();
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int n = 0; n < 4000 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("pass_completes", seen, 1);
    @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic wait_hs(input int n);
    bit seen = 0;
    for (int k = 0; k < 4000 && !seen; k++) begin
      @(posedge clk);
      if (hs_count >= n) seen = 1;
    end
    check("handshake_reached", seen, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_re_p"}, re_p, 0);
    check({tag, "_read_addressp"}, read_addressp, 0);
    check({tag, "_win_valid"}, win_valid, 0);
    check({tag, "_win_data"}, win_data == '0, 1);
    check({tag, "_win_row"}, win_row, 0);
    check({tag, "_win_col"}, win_col, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // mem[a] = a, base 0, always ready.
    ram_key = '0; ready_pct = 100;
    pulse_start(16'd0, 1);
    wait_done();

    // base 100 with a long stall on window (0,1).
    pulse_start(16'd100, 1);
    wait_hs(1);
    stall_cnt = 30;
    wait_done();

    // Random backpressure, random contents, start poked while busy.
    ram_key = W'($urandom()); ready_pct = 60;
    pulse_start(AW'($urandom()), 1);
    repeat (15) @(posedge clk);
    check("busy_mid_pass", busy, 1);
    pulse_start(AW'($urandom()), 0);
    wait_done();

    // Reset during the fetch of window 4, then a fresh pass from (0,0).
    ram_key = '0; ready_pct = 100;
    pulse_start(16'd40, 1);
    wait_hs(4);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("abort");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(negedge clk) check("no_done_after_abort", done, 0);
    pulse_start(16'd7, 1);
    wait_done();

    // Randomized passes, one straddling the top of the address space.
    for (int p = 0; p < 4; p++) begin
      ram_key   = W'($urandom());
      ready_pct = $urandom_range(30, 100);
      pulse_start((p == 0) ? 16'hFFF0 : AW'($urandom()), 1);
      wait_done();
    end

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
